// File: rtl/sobel_edge_frame.sv
// Frame-buffered Sobel edge detector: loads one W x H grayscale frame, then
// streams out the saturated exact gradient magnitude of every pixel in raster order.
module sobel_edge_frame #(
  parameter int W = 630,
  parameter int H = 630
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [7:0] in_pixel,
  output logic       out_valid,
  output logic [7:0] out_pixel
);

  localparam int AW = $clog2(W * H);
  localparam int CW = $clog2(W);
  localparam int RW = $clog2(H);
  localparam logic [AW-1:0] LAST_A  = AW'(W * H - 1);
  localparam logic [AW-1:0] W_A     = AW'(W);
  localparam logic [AW-1:0] ONE_A   = AW'(1);
  localparam logic [CW-1:0] LAST_C  = CW'(W - 1);
  localparam logic [RW-1:0] LAST_R  = RW'(H - 1);

  typedef enum logic [2:0] {
    S_LOAD, S_START, S_FETCH, S_CALC, S_SQRT, S_EMIT
  } state_t;

  state_t          state_r;
  logic [AW-1:0]   wr_cnt_r;
  logic [AW-1:0]   p_r;
  logic [CW-1:0]   col_r;
  logic [RW-1:0]   row_r;
  logic [3:0]      k_r;
  logic [3:0]      iter_r;
  logic [21:0]     rad_r;
  logic [13:0]     rem_r;
  logic [10:0]     root_r;
  logic [7:0]      win_r [0:8];
  logic [7:0]      mem_r [0:W*H-1];
  logic [7:0]      rd_data_r;
  logic            out_valid_r;
  logic [7:0]      out_pixel_r;

  logic [AW-1:0]        rd_addr_s;
  logic signed [11:0]   tap_s [0:8];
  logic signed [11:0]   gx_s;
  logic signed [11:0]   gy_s;
  logic [10:0]          ax_s;
  logic [10:0]          ay_s;
  logic [21:0]          sq_sum_s;
  logic [13:0]          rem_sh_s;
  logic [13:0]          trial_s;
  logic                 border_s;

  assign out_valid = out_valid_r;
  assign out_pixel = out_pixel_r;

  // Neighbourhood tap address, taps numbered row-major from top-left.
  always_comb begin
    rd_addr_s = p_r;
    case (k_r)
      4'd0:    rd_addr_s = p_r - W_A - ONE_A;
      4'd1:    rd_addr_s = p_r - W_A;
      4'd2:    rd_addr_s = p_r - W_A + ONE_A;
      4'd3:    rd_addr_s = p_r - ONE_A;
      4'd4:    rd_addr_s = p_r;
      4'd5:    rd_addr_s = p_r + ONE_A;
      4'd6:    rd_addr_s = p_r + W_A - ONE_A;
      4'd7:    rd_addr_s = p_r + W_A;
      4'd8:    rd_addr_s = p_r + W_A + ONE_A;
      default: rd_addr_s = p_r;
    endcase
  end

  // Sobel gradients, their squared magnitude and one restoring square-root step.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      tap_s[i] = $signed({4'b0000, win_r[i]});
    end
    gx_s = tap_s[2] + (tap_s[5] <<< 1) + tap_s[8] - tap_s[0] - (tap_s[3] <<< 1) - tap_s[6];
    gy_s = tap_s[6] + (tap_s[7] <<< 1) + tap_s[8] - tap_s[0] - (tap_s[1] <<< 1) - tap_s[2];
    if (gx_s[11]) begin
      ax_s = 11'(-gx_s);
    end else begin
      ax_s = gx_s[10:0];
    end
    if (gy_s[11]) begin
      ay_s = 11'(-gy_s);
    end else begin
      ay_s = gy_s[10:0];
    end
    sq_sum_s = (22'(ax_s) * 22'(ax_s)) + (22'(ay_s) * 22'(ay_s));
    rem_sh_s = 14'(rem_r << 2) | {12'b0, rad_r[21:20]};
    trial_s  = {1'b0, root_r, 2'b01};
    border_s = (row_r == '0) || (row_r == LAST_R) || (col_r == '0) || (col_r == LAST_C);
  end

  // Frame buffer: written during LOAD, one registered read per cycle.
  always_ff @(posedge clk) begin
    if (state_r == S_LOAD && in_valid) begin
      mem_r[wr_cnt_r] <= in_pixel;
    end
    rd_data_r <= mem_r[rd_addr_s];
  end

  // Control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_LOAD;
      wr_cnt_r    <= '0;
      p_r         <= '0;
      col_r       <= '0;
      row_r       <= '0;
      k_r         <= 4'd0;
      iter_r      <= 4'd0;
      rad_r       <= 22'd0;
      rem_r       <= 14'd0;
      root_r      <= 11'd0;
      out_valid_r <= 1'b0;
      out_pixel_r <= 8'd0;
      for (int i = 0; i < 9; i++) begin
        win_r[i] <= 8'd0;
      end
    end else begin
      out_valid_r <= 1'b0;
      case (state_r)
        S_LOAD: begin
          if (in_valid) begin
            if (wr_cnt_r == LAST_A) begin
              wr_cnt_r <= '0;
              state_r  <= S_START;
            end else begin
              wr_cnt_r <= wr_cnt_r + ONE_A;
            end
          end
        end
        S_START: begin
          k_r <= 4'd0;
          if (border_s) begin
            root_r  <= 11'd0;
            state_r <= S_EMIT;
          end else begin
            state_r <= S_FETCH;
          end
        end
        S_FETCH: begin
          // Read data lags the issued address by one cycle, so tap k lands at k+1.
          if (k_r != 4'd0) begin
            for (int i = 0; i < 8; i++) begin
              win_r[i] <= win_r[i+1];
            end
            win_r[8] <= rd_data_r;
          end
          if (k_r == 4'd9) begin
            state_r <= S_CALC;
          end else begin
            k_r <= k_r + 4'd1;
          end
        end
        S_CALC: begin
          rad_r   <= sq_sum_s;
          rem_r   <= 14'd0;
          root_r  <= 11'd0;
          iter_r  <= 4'd0;
          state_r <= S_SQRT;
        end
        S_SQRT: begin
          if (rem_sh_s >= trial_s) begin
            rem_r  <= rem_sh_s - trial_s;
            root_r <= {root_r[9:0], 1'b1};
          end else begin
            rem_r  <= rem_sh_s;
            root_r <= {root_r[9:0], 1'b0};
          end
          rad_r  <= {rad_r[19:0], 2'b00};
          iter_r <= iter_r + 4'd1;
          if (iter_r == 4'd10) begin
            state_r <= S_EMIT;
          end
        end
        S_EMIT: begin
          out_valid_r <= 1'b1;
          out_pixel_r <= (root_r[10:8] != 3'd0) ? 8'hFF : root_r[7:0];
          if (p_r == LAST_A) begin
            p_r     <= '0;
            col_r   <= '0;
            row_r   <= '0;
            state_r <= S_LOAD;
          end else begin
            p_r <= p_r + ONE_A;
            if (col_r == LAST_C) begin
              col_r <= '0;
              row_r <= row_r + RW'(1);
            end else begin
              col_r <= col_r + CW'(1);
            end
            state_r <= S_START;
          end
        end
        default: state_r <= S_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_sobel_edge_frame.sv
// Directed bench for sobel_edge_frame on a 5x5 frame with hand-computed edge images.
module tb_sobel_edge_frame;

  localparam int N = 25;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic [7:0] out_pixel;

  int checks_cnt;
  int errors_cnt;
  logic [7:0] frame_mem [N];
  int exp_mem [N];
  int out_q [$];

  sobel_edge_frame #(.W(5), .H(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_pixel  (in_pixel),
    .out_valid (out_valid),
    .out_pixel (out_pixel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Capture every output pulse away from the active edge.
  always @(negedge clk) begin
    if (out_valid) out_q.push_back(int'(out_pixel));
  end

  task automatic check_val(input string tag, input int obs, input int exp);
    checks_cnt++;
    if (obs != exp) begin
      errors_cnt++;
      $display("FAIL %s got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input bit gap);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      in_pixel = frame_mem[i];
      @(posedge clk); #1;
      if (gap) begin
        in_valid = 1'b0;
        in_pixel = 8'hAA;
        @(posedge clk); #1;
      end
    end
    in_valid = 1'b0;
  endtask

  // Wait for a full frame of outputs, optionally pushing junk input meanwhile.
  task automatic collect(input string name, input bit extra);
    int cyc;
    cyc = 0;
    while (out_q.size() < N && cyc < 5000) begin
      if (extra) begin
        in_valid = (out_q.size() < 20);
        in_pixel = 8'h55;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    check_val({name, "_count"}, out_q.size(), N);
    repeat (60) @(posedge clk);
    #1;
    check_val({name, "_no_extra"}, out_q.size(), N);
    for (int i = 0; i < N; i++) begin
      check_val($sformatf("%s[%0d]", name, i), (i < out_q.size()) ? out_q[i] : -1, exp_mem[i]);
    end
    out_q.delete();
  endtask

  task automatic set_step();
    for (int i = 0; i < N; i++) begin
      frame_mem[i] = ((i % 5) >= 2) ? 8'd255 : 8'd0;
    end
    exp_mem = '{0, 0,   0,   0, 0,
                0, 255, 255, 0, 0,
                0, 255, 255, 0, 0,
                0, 255, 255, 0, 0,
                0, 0,   0,   0, 0};
  endtask

  task automatic set_dot(input logic [7:0] v);
    for (int i = 0; i < N; i++) frame_mem[i] = 8'd0;
    frame_mem[12] = v;
  endtask

  initial begin
    checks_cnt = 0;
    errors_cnt = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_pixel = 8'd0;

    // Reset held, then idle: outputs must stay quiet.
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (c == 9) rst = 1'b0;
      check_val("reset_valid", int'(out_valid), 0);
      check_val("reset_pixel", int'(out_pixel), 0);
    end

    for (int i = 0; i < N; i++) frame_mem[i] = 8'h80;
    for (int i = 0; i < N; i++) exp_mem[i] = 0;
    send_frame(1'b0);
    collect("const", 1'b0);

    set_step();
    send_frame(1'b0);
    collect("step", 1'b0);

    set_dot(8'd10);
    exp_mem = '{0, 0,  0,  0,  0,
                0, 14, 20, 14, 0,
                0, 20, 0,  20, 0,
                0, 14, 20, 14, 0,
                0, 0,  0,  0,  0};
    send_frame(1'b0);
    collect("dot10", 1'b0);

    set_dot(8'd128);
    exp_mem = '{0, 0,   0,   0,   0,
                0, 181, 255, 181, 0,
                0, 255, 0,   255, 0,
                0, 181, 255, 181, 0,
                0, 0,   0,   0,   0};
    send_frame(1'b0);
    collect("dot128", 1'b0);

    set_step();
    send_frame(1'b1);
    collect("gapped", 1'b1);

    // Reset in the middle of outputting a step frame.
    set_step();
    send_frame(1'b0);
    for (int c = 0; c < 3000 && out_q.size() < 10; c++) begin
      @(posedge clk); #1;
    end
    check_val("mid_partial", (out_q.size() >= 10) ? 1 : 0, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    check_val("mid_rst_valid", int'(out_valid), 0);
    check_val("mid_rst_pixel", int'(out_pixel), 0);
    rst = 1'b0;
    out_q.delete();
    repeat (40) @(posedge clk);
    #1;
    check_val("mid_quiet", out_q.size(), 0);

    for (int i = 0; i < N; i++) frame_mem[i] = 8'd0;
    for (int i = 0; i < N; i++) exp_mem[i] = 0;
    send_frame(1'b0);
    collect("after_rst", 1'b0);

    set_dot(8'd10);
    exp_mem = '{0, 0,  0,  0,  0,
                0, 14, 20, 14, 0,
                0, 20, 0,  20, 0,
                0, 14, 20, 14, 0,
                0, 0,  0,  0,  0};
    send_frame(1'b0);
    collect("second", 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
